// File: rtl/button_debounce.sv
// button_debounce: per-channel input conditioning for N_BTN raw buttons.
// Each channel is synchronised, debounced into a stable level, and produces
// one-cycle press/release pulses plus a one-shot long-press (hold) pulse.
module button_debounce #(
    parameter int N_BTN           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 600000,
    parameter int HOLD_CYCLES     = 6000000,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_hold,
    output logic             any_press
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HCNT_LAST = HW'(HOLD_CYCLES - 1);

    logic [N_BTN-1:0] raw_norm;
    logic [N_BTN-1:0] s;
    logic [N_BTN-1:0] sync_q [SYNC_STAGES];

    logic [DW-1:0]    dcnt_q [N_BTN];
    logic [DW-1:0]    dcnt_d [N_BTN];
    logic [HW-1:0]    hcnt_q [N_BTN];
    logic [HW-1:0]    hcnt_d [N_BTN];

    logic [N_BTN-1:0] hold_done_q;
    logic [N_BTN-1:0] hold_done_d;
    logic [N_BTN-1:0] level_d;
    logic [N_BTN-1:0] press_d;
    logic [N_BTN-1:0] release_d;
    logic [N_BTN-1:0] hold_d;

    // Polarity is normalised before the synchroniser so that 1 always means pressed.
    assign raw_norm = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;
    assign s        = sync_q[SYNC_STAGES-1];

    // Multi-stage synchroniser for the asynchronous raw inputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= raw_norm;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Next-state for debounce and hold counters, levels and pulses per channel.
    always_comb begin
        level_d     = btn_level;
        press_d     = '0;
        release_d   = '0;
        hold_d      = '0;
        hold_done_d = hold_done_q;
        for (int unsigned c = 0; c < N_BTN; c++) begin
            dcnt_d[c] = dcnt_q[c];
            hcnt_d[c] = hcnt_q[c];

            // Any sample matching the accepted level restarts the count.
            if (s[c] == btn_level[c]) begin
                dcnt_d[c] = '0;
            end else if (dcnt_q[c] == DCNT_LAST) begin
                dcnt_d[c]    = '0;
                level_d[c]   = s[c];
                press_d[c]   = s[c];
                release_d[c] = ~s[c];
            end else begin
                dcnt_d[c] = dcnt_q[c] + DW'(1);
            end

            // A release accepted on this edge suppresses a hold due on the same edge.
            if (!btn_level[c] || release_d[c]) begin
                hcnt_d[c]      = '0;
                hold_done_d[c] = 1'b0;
            end else if (!hold_done_q[c]) begin
                if (hcnt_q[c] == HCNT_LAST) begin
                    hold_d[c]      = 1'b1;
                    hold_done_d[c] = 1'b1;
                end else begin
                    hcnt_d[c] = hcnt_q[c] + HW'(1);
                end
            end
        end
    end

    // State and registered output update.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned c = 0; c < N_BTN; c++) begin
                dcnt_q[c] <= '0;
                hcnt_q[c] <= '0;
            end
            hold_done_q <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            btn_hold    <= '0;
            any_press   <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < N_BTN; c++) begin
                dcnt_q[c] <= dcnt_d[c];
                hcnt_q[c] <= hcnt_d[c];
            end
            hold_done_q <= hold_done_d;
            btn_level   <= level_d;
            btn_press   <= press_d;
            btn_release <= release_d;
            btn_hold    <= hold_d;
            any_press   <= |press_d;
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// Testbench for button_debounce: expected output events are queued as stimulus
// is driven and matched against events recorded from the DUT outputs.
module tb_button_debounce;

    localparam int N   = 2;
    localparam int SS  = 2;
    localparam int DEB = 4;
    localparam int HLD = 10;

    typedef struct packed {
        logic [31:0] cyc;
        logic [1:0]  level;
        logic [1:0]  press;
        logic [1:0]  rel;
        logic [1:0]  hold;
        logic        any;
    } ev_t;

    logic         clock = 1'b0;
    logic         reset_n = 1'b1;
    logic [N-1:0] raw = '0;
    logic [N-1:0] raw_al = '1;

    logic [N-1:0] level, press, rel, hold;
    logic         any;
    logic [N-1:0] level_al, press_al, rel_al, hold_al;
    logic         any_al;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    ev_t exp_q[$];
    ev_t obs_q[$];
    ev_t exp_al_q[$];
    ev_t obs_al_q[$];

    button_debounce #(
        .N_BTN(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HLD), .ACTIVE_LOW(0)
    ) dut (
        .clock(clock), .reset_n(reset_n), .btn_raw(raw),
        .btn_level(level), .btn_press(press), .btn_release(rel),
        .btn_hold(hold), .any_press(any)
    );

    button_debounce #(
        .N_BTN(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HLD), .ACTIVE_LOW(1)
    ) dut_al (
        .clock(clock), .reset_n(reset_n), .btn_raw(raw_al),
        .btn_level(level_al), .btn_press(press_al), .btn_release(rel_al),
        .btn_hold(hold_al), .any_press(any_al)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Record every cycle that carries a pulse, away from the active edge.
    always @(negedge clock) begin
        if (reset_n && ((press | rel | hold) != '0 || any))
            obs_q.push_back('{cyc: cyc, level: level, press: press, rel: rel, hold: hold, any: any});
        if (reset_n && ((press_al | rel_al | hold_al) != '0 || any_al))
            obs_al_q.push_back('{cyc: cyc, level: level_al, press: press_al, rel: rel_al, hold: hold_al, any: any_al});
    end

    function automatic ev_t mk(input int c, input logic [1:0] l, input logic [1:0] p,
                               input logic [1:0] r, input logic [1:0] h, input logic a);
        ev_t e;
        e.cyc = c; e.level = l; e.press = p; e.rel = r; e.hold = h; e.any = a;
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic test_reset();
        ev_t e, o;
        int c;
        raw = 2'b11;
        raw_al = 2'b11;
        #2 reset_n = 1'b0;
        tick(3);
        #1;
        n_checks++;
        if ({level, press, rel, hold, any} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset outputs: got %b expected %b", {level, press, rel, hold, any}, 9'd0);
        end
        n_checks++;
        if ({level_al, press_al, rel_al, hold_al, any_al} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset outputs_al: got %b expected %b", {level_al, press_al, rel_al, hold_al, any_al}, 9'd0);
        end
        obs_q.delete(); exp_q.delete(); obs_al_q.delete();
        tick(1);
        c = cyc;
        reset_n = 1'b1;
        exp_q.push_back(mk(c + 6,  2'b11, 2'b11, 2'b00, 2'b00, 1'b1));
        exp_q.push_back(mk(c + 16, 2'b11, 2'b00, 2'b00, 2'b11, 1'b0));
        tick(20);
        c = cyc;
        raw = 2'b00;
        exp_q.push_back(mk(c + 6,  2'b00, 2'b00, 2'b11, 2'b00, 1'b0));
        tick(10);
        #1;
        n_checks++;
        if (obs_al_q.size() !== 0) begin
            n_fail++;
            $display("FAIL reset al_events: got %0d expected 0", obs_al_q.size());
        end
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL reset event_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset event: got cyc=%0d lvl=%b prs=%b rel=%b hld=%b any=%b expected cyc=%0d lvl=%b prs=%b rel=%b hld=%b any=%b",
                         o.cyc, o.level, o.press, o.rel, o.hold, o.any, e.cyc, e.level, e.press, e.rel, e.hold, e.any);
            end
        end
    endtask

    task automatic test_clean_press();
        ev_t e, o;
        int c;
        tick(1);
        obs_q.delete(); exp_q.delete();
        c = cyc;
        raw = 2'b01;
        exp_q.push_back(mk(c + 6,  2'b01, 2'b01, 2'b00, 2'b00, 1'b1));
        tick(8);
        raw = 2'b00;
        exp_q.push_back(mk(c + 14, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0));
        tick(12);
        #1;
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL clean_press event_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL clean_press event: got cyc=%0d lvl=%b prs=%b rel=%b hld=%b any=%b expected cyc=%0d lvl=%b prs=%b rel=%b hld=%b any=%b",
                         o.cyc, o.level, o.press, o.rel, o.hold, o.any, e.cyc, e.level, e.press, e.rel, e.hold, e.any);
            end
        end
    endtask

    task automatic test_bounce();
        ev_t e, o;
        int c;
        logic pat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tick(1);
        obs_q.delete(); exp_q.delete();
        c = cyc;
        // Only raw samples 4..7 form four consecutive 1s: accepted 9 edges after the first.
        exp_q.push_back(mk(c + 10, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1));
        exp_q.push_back(mk(c + 20, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0));
        for (int i = 0; i < 8; i++) begin
            raw = {1'b0, pat[i]};
            tick(1);
        end
        tick(17);
        raw = 2'b00;
        exp_q.push_back(mk(c + 31, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0));
        tick(12);
        #1;
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL bounce event_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL bounce event: got cyc=%0d lvl=%b prs=%b rel=%b hld=%b any=%b expected cyc=%0d lvl=%b prs=%b rel=%b hld=%b any=%b",
                         o.cyc, o.level, o.press, o.rel, o.hold, o.any, e.cyc, e.level, e.press, e.rel, e.hold, e.any);
            end
        end
    endtask

    task automatic test_hold();
        ev_t e, o;
        int c;
        tick(1);
        obs_q.delete(); exp_q.delete();
        c = cyc;
        raw = 2'b10;
        exp_q.push_back(mk(c + 6,  2'b10, 2'b10, 2'b00, 2'b00, 1'b1));
        exp_q.push_back(mk(c + 16, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0));
        tick(30);
        raw = 2'b00;
        exp_q.push_back(mk(c + 36, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0));
        tick(10);
        raw = 2'b10;
        exp_q.push_back(mk(c + 46, 2'b10, 2'b10, 2'b00, 2'b00, 1'b1));
        exp_q.push_back(mk(c + 56, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0));
        tick(20);
        raw = 2'b00;
        exp_q.push_back(mk(c + 66, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0));
        tick(12);
        #1;
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL hold event_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL hold event: got cyc=%0d lvl=%b prs=%b rel=%b hld=%b any=%b expected cyc=%0d lvl=%b prs=%b rel=%b hld=%b any=%b",
                         o.cyc, o.level, o.press, o.rel, o.hold, o.any, e.cyc, e.level, e.press, e.rel, e.hold, e.any);
            end
        end
    endtask

    task automatic test_release_reset();
        ev_t e, o;
        int c;
        tick(1);
        obs_q.delete(); exp_q.delete();
        // Release accepted one edge before the hold is due.
        c = cyc;
        raw = 2'b01;
        exp_q.push_back(mk(c + 6,  2'b01, 2'b01, 2'b00, 2'b00, 1'b1));
        tick(9);
        raw = 2'b00;
        exp_q.push_back(mk(c + 15, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0));
        tick(12);
        // Release accepted on the very edge the hold would fire.
        c = cyc;
        raw = 2'b01;
        exp_q.push_back(mk(c + 6,  2'b01, 2'b01, 2'b00, 2'b00, 1'b1));
        tick(10);
        raw = 2'b00;
        exp_q.push_back(mk(c + 16, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0));
        tick(12);
        // Reset asserted while a release is being debounced.
        c = cyc;
        raw = 2'b01;
        exp_q.push_back(mk(c + 6,  2'b01, 2'b01, 2'b00, 2'b00, 1'b1));
        tick(8);
        #1;
        n_checks++;
        if (level !== 2'b01) begin
            n_fail++;
            $display("FAIL release_reset level_before_reset: got %b expected %b", level, 2'b01);
        end
        raw = 2'b00;
        tick(3);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({level, press, rel, hold, any} !== 9'd0) begin
            n_fail++;
            $display("FAIL release_reset outputs_in_reset: got %b expected %b", {level, press, rel, hold, any}, 9'd0);
        end
        tick(2);
        reset_n = 1'b1;
        tick(15);
        #1;
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL release_reset event_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL release_reset event: got cyc=%0d lvl=%b prs=%b rel=%b hld=%b any=%b expected cyc=%0d lvl=%b prs=%b rel=%b hld=%b any=%b",
                         o.cyc, o.level, o.press, o.rel, o.hold, o.any, e.cyc, e.level, e.press, e.rel, e.hold, e.any);
            end
        end
    endtask

    task automatic test_active_low();
        ev_t e, o;
        int c;
        tick(1);
        obs_q.delete(); obs_al_q.delete(); exp_al_q.delete();
        c = cyc;
        raw_al = 2'b00;
        exp_al_q.push_back(mk(c + 6,  2'b11, 2'b11, 2'b00, 2'b00, 1'b1));
        exp_al_q.push_back(mk(c + 16, 2'b11, 2'b00, 2'b00, 2'b11, 1'b0));
        tick(20);
        raw_al = 2'b11;
        exp_al_q.push_back(mk(c + 26, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0));
        tick(12);
        #1;
        n_checks++;
        if (obs_q.size() !== 0) begin
            n_fail++;
            $display("FAIL active_low main_events: got %0d expected 0", obs_q.size());
        end
        n_checks++;
        if (obs_al_q.size() !== exp_al_q.size()) begin
            n_fail++;
            $display("FAIL active_low event_count: got %0d expected %0d", obs_al_q.size(), exp_al_q.size());
        end
        while (exp_al_q.size() > 0 && obs_al_q.size() > 0) begin
            e = exp_al_q.pop_front(); o = obs_al_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL active_low event: got cyc=%0d lvl=%b prs=%b rel=%b hld=%b any=%b expected cyc=%0d lvl=%b prs=%b rel=%b hld=%b any=%b",
                         o.cyc, o.level, o.press, o.rel, o.hold, o.any, e.cyc, e.level, e.press, e.rel, e.hold, e.any);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_hold();
        test_release_reset();
        test_active_low();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
